adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL run on one clock; reset SHALL be asynchronous and active-high, ports clk and rst.
REQ-002 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 Parameter W, default 32, operand and result width.
REQ-004 clk  input  1  clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req  input  N_REQ  per-requester request, held with operands until granted.
REQ-007 op_a  input  N_REQ*W  operand A, requester i at bits [i*W +: W].
REQ-008 op_b  input  N_REQ*W  operand B, same packing.
REQ-009 op_sub  input  N_REQ  1 = A-B, 0 = A+B.
REQ-010 gnt  output  N_REQ  one-hot, one-cycle grant; operands captured in that cycle.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 rsp_id  output  clog2(N_REQ)  index of requester owning the result.
REQ-015 rsp_f  output  W  sum/difference.
REQ-016 rsp_of, rsp_sf, rsp_zf, rsp_cf  output  1 each  overflow, sign, zero, carry/borrow flags.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, DONE.
REQ-018 IDLE: if any req high, select winner by round-robin from pointer ptr (first set bit at or above ptr, wrapping past N_REQ-1 to 0), assert gnt[winner] combinationally, latch operands/op_sub/id, go to EXEC; else stay IDLE with gnt=0.
REQ-019 EXEC: compute on latched operands, register result and flags at end of cycle, go to DONE; gnt=0.
REQ-020 DONE: rsp_valid=1; rsp_* SHALL hold stable until rsp_ready=1, then go to IDLE and set ptr = winner+1 modulo N_REQ.
REQ-021 Latency: grant in cycle T, rsp_valid from T+2; minimum 3 cycles per operation; no grant while busy.
REQ-022 Arithmetic: B' = op_sub ? ~B : B; {cout, F} = A + B' + op_sub in W+1 bits.
REQ-023 Flags: OF = (A[W-1]==B'[W-1]) && (F[W-1]!=A[W-1]); SF = F[W-1]; ZF = (F==0); CF = cout XOR op_sub (borrow on subtract).
REQ-024 req withdrawn before grant SHALL simply not be granted; no grant to a requester with req low.
REQ-025 Outputs rsp_* outside DONE SHALL retain last result; rsp_valid=0.

Reset
REQ-026 rst SHALL immediately force state IDLE, ptr=0, gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_f=0, all flags 0, latched operands 0.
REQ-027 rst during EXEC or DONE SHALL discard the operation with no response issued.

Structure
REQ-028 A shared package adder_arb_pkg SHALL hold state encoding constants (IDLE=0, EXEC=1, DONE=2) and default N_REQ/W.
REQ-029 One sub-module arb_add_core SHALL implement combinational REQ-022/023 (A, B, sub -> F, OF, SF, ZF, CF); FSM, arbitration and registers in adder_arbiter.

Verification
REQ-030 req[0], add 0x7FFFFFFF+0x1 -> gnt[0] one cycle, rsp_valid at T+2, rsp_f=0x80000000, OF=1, SF=1, ZF=0, CF=0, rsp_id=0.
REQ-031 req[1] sub 5-5 -> rsp_f=0, ZF=1, CF=0; then sub 3-5 -> rsp_f=0xFFFFFFFE, SF=1, CF=1, OF=0.
REQ-032 All four req high after reset, rsp_ready=1 -> grants 0,1,2,3 each 3 cycles apart, rsp_id matches each.
REQ-033 rsp_ready low 5 cycles in DONE -> rsp_valid and rsp_* stable, busy=1, no gnt despite pending req.
REQ-034 After serving requester 3 (ptr wraps to 0), req[0] and req[3] high -> gnt[0] first.
REQ-035 rst pulsed in EXEC -> all outputs 0 asynchronously, no rsp_valid afterwards, next grant goes to lowest-index requester.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the arbitrated adder/subtractor: FSM state
// encoding and the default requester count and datapath width.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 32;

endpackage

// File: rtl/arb_add_core.sv
// Combinational add/subtract core with overflow, sign, zero and
// carry/borrow flags. Subtraction is done as A + ~B + 1.
module arb_add_core
  import adder_arb_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] f,
  output logic         of,
  output logic         sf,
  output logic         zf,
  output logic         cf
);

  logic [W-1:0] b_eff;
  logic [W:0]   sum;

  assign b_eff = sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
  assign f     = sum[W-1:0];
  assign of    = (a[W-1] == b_eff[W-1]) && (f[W-1] != a[W-1]);
  assign sf    = f[W-1];
  assign zf    = (f == '0);
  // On subtract the carry out is the inverse of a borrow.
  assign cf    = sum[W] ^ sub;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of a shared adder/subtractor. A granted
// requester's operands are captured, computed in EXEC, and the result is
// held in DONE until the consumer accepts it.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ*W-1:0]             op_a,
  input  logic [N_REQ*W-1:0]             op_b,
  input  logic [N_REQ-1:0]               op_sub,
  output logic [N_REQ-1:0]               gnt,
  output logic                           busy,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(N_REQ)-1:0]       rsp_id,
  output logic [W-1:0]                   rsp_f,
  output logic                           rsp_of,
  output logic                           rsp_sf,
  output logic                           rsp_zf,
  output logic                           rsp_cf
);

  localparam int IDW = $clog2(N_REQ);

  state_t         state, state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] winner;
  logic           found;
  logic [IDW:0]   sum_idx;
  logic [W-1:0]   lat_a, lat_b;
  logic           lat_sub;
  logic           grant_fire;

  logic [W-1:0]   core_f;
  logic           core_of, core_sf, core_zf, core_cf;

  // Round-robin pick: first requester at or above ptr, wrapping to 0.
  // Scanning offsets from high to low lets the smallest offset win.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    sum_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum_idx = {1'b0, ptr} + {1'b0, IDW'(k)};
      if (sum_idx >= (IDW+1)'(N_REQ)) sum_idx = sum_idx - (IDW+1)'(N_REQ);
      if (req[sum_idx[IDW-1:0]]) begin
        winner = sum_idx[IDW-1:0];
        found  = 1'b1;
      end
    end
  end

  assign grant_fire = (state == IDLE) && found && !rst;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs; grant is only ever issued from IDLE.
  always_comb begin
    state_next = state;
    gnt        = '0;
    busy       = 1'b1;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant_fire) begin
          gnt        = N_REQ'(1) << winner;
          state_next = EXEC;
        end
      end
      EXEC: state_next = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the winner's operands and identity in the grant cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_a   <= '0;
      lat_b   <= '0;
      lat_sub <= 1'b0;
      cur_id  <= '0;
    end else if (grant_fire) begin
      lat_a   <= op_a[winner*W +: W];
      lat_b   <= op_b[winner*W +: W];
      lat_sub <= op_sub[winner];
      cur_id  <= winner;
    end
  end

  arb_add_core #(.W(W)) u_core (
    .a   (lat_a),
    .b   (lat_b),
    .sub (lat_sub),
    .f   (core_f),
    .of  (core_of),
    .sf  (core_sf),
    .zf  (core_zf),
    .cf  (core_cf)
  );

  // Result registers load at the end of EXEC and otherwise keep the last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_f  <= '0;
      rsp_of <= 1'b0;
      rsp_sf <= 1'b0;
      rsp_zf <= 1'b0;
      rsp_cf <= 1'b0;
      rsp_id <= '0;
    end else if (state == EXEC) begin
      rsp_f  <= core_f;
      rsp_of <= core_of;
      rsp_sf <= core_sf;
      rsp_zf <= core_zf;
      rsp_cf <= core_cf;
      rsp_id <= cur_id;
    end
  end

  // Priority pointer moves past the served requester once its result is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == DONE && rsp_ready) begin
      ptr <= (cur_id == IDW'(N_REQ - 1)) ? '0 : cur_id + IDW'(1);
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed arithmetic cases,
// round-robin order, back-pressure, reset mid-operation and random traffic
// compared against a plain-arithmetic reference model.
module tb_adder_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a, op_b;
  logic [N-1:0]   op_sub;
  logic [N-1:0]   gnt;
  logic           busy, rsp_valid, rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_f;
  logic           rsp_of, rsp_sf, rsp_zf, rsp_cf;

  logic [W-1:0]   a_val [N];
  logic [W-1:0]   b_val [N];
  logic           s_val [N];

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;

  typedef struct packed {
    logic [W-1:0] f;
    logic [3:0]   flags;
  } res_t;

  typedef struct {
    logic [N-1:0]   g0;
    logic [N-1:0]   g1;
    logic           busy1;
    logic           v1;
    logic           v2;
    logic [W-1:0]   f;
    logic [3:0]     flags;
    logic [IDW-1:0] id;
  } obs_t;

  adder_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_f     (rsp_f),
    .rsp_of    (rsp_of),
    .rsp_sf    (rsp_sf),
    .rsp_zf    (rsp_zf),
    .rsp_cf    (rsp_cf)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: unsigned result and borrow, signed range check for overflow.
  function automatic res_t model_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint ua, ub, sa, sb, ru, rs;
    res_t r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      ru = ua - ub;
      rs = sa - sb;
      r.flags[0] = (ua < ub);
    end else begin
      ru = ua + ub;
      rs = sa + sb;
      r.flags[0] = ru[32];
    end
    r.f        = ru[31:0];
    r.flags[3] = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
    r.flags[2] = r.f[31];
    r.flags[1] = (r.f == 0);
    return r;
  endfunction

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int model_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (((r >> i) & N'(1)) != 0) return i;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    a_val[i] = a;
    b_val[i] = b;
    s_val[i] = s;
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
    op_sub = (op_sub & ~(N'(1) << i)) | (N'(s) << i);
  endtask

  // Drives one full grant/compute/respond sequence and records what the DUT showed.
  task automatic run_txn(input logic [N-1:0] mask, output obs_t o);
    req = mask;
    #1;
    o.g0 = gnt;
    step();
    req = req & ~o.g0;
    #1;
    o.g1    = gnt;
    o.busy1 = busy;
    o.v1    = rsp_valid;
    step();
    #1;
    o.v2    = rsp_valid;
    o.f     = rsp_f;
    o.flags = {rsp_of, rsp_sf, rsp_zf, rsp_cf};
    o.id    = rsp_id;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
    #1;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req       = '0;
    rsp_ready = 1'b1;
    op_a      = '0;
    op_b      = '0;
    op_sub    = '0;
    for (int i = 0; i < N; i++) load_op(i, '0, '0, 1'b0);
    #3;
    checks++; if (gnt !== '0)       begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 0", gnt); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_id !== '0)    begin errors++; $display("[TB] FAIL reset_id: got %0d expected 0", rsp_id); end
    checks++; if (rsp_f !== '0)     begin errors++; $display("[TB] FAIL reset_f: got %h expected 0", rsp_f); end
    checks++; if ({rsp_of, rsp_sf, rsp_zf, rsp_cf} !== 4'b0)
      begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {rsp_of, rsp_sf, rsp_zf, rsp_cf}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    m_ptr = 0;
  endtask

  task automatic test_directed();
    int           tid [3]  = '{0, 1, 1};
    logic [W-1:0] ta  [3]  = '{32'h7FFF_FFFF, 32'd5, 32'd3};
    logic [W-1:0] tb  [3]  = '{32'h0000_0001, 32'd5, 32'd5};
    logic         ts  [3]  = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] tf  [3]  = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFE};
    logic [3:0]   tfl [3]  = '{4'b1100, 4'b0010, 4'b0101};
    obs_t o;
    for (int t = 0; t < 3; t++) begin
      logic [N-1:0] exp_g;
      exp_g = N'(1) << tid[t];
      load_op(tid[t], ta[t], tb[t], ts[t]);
      run_txn(exp_g, o);
      checks++; if (o.g0 !== exp_g)  begin errors++; $display("[TB] FAIL directed_gnt[%0d]: got %b expected %b", t, o.g0, exp_g); end
      checks++; if (o.g1 !== '0)     begin errors++; $display("[TB] FAIL directed_gnt_one_cycle[%0d]: got %b expected 0", t, o.g1); end
      checks++; if (o.v1 !== 1'b0)   begin errors++; $display("[TB] FAIL directed_valid_early[%0d]: got %b expected 0", t, o.v1); end
      checks++; if (o.v2 !== 1'b1)   begin errors++; $display("[TB] FAIL directed_valid_t2[%0d]: got %b expected 1", t, o.v2); end
      checks++; if (o.f !== tf[t])   begin errors++; $display("[TB] FAIL directed_f[%0d]: got %h expected %h", t, o.f, tf[t]); end
      checks++; if (o.flags !== tfl[t]) begin errors++; $display("[TB] FAIL directed_flags[%0d]: got %b expected %b", t, o.flags, tfl[t]); end
      checks++; if (o.id !== IDW'(tid[t])) begin errors++; $display("[TB] FAIL directed_id[%0d]: got %0d expected %0d", t, o.id, tid[t]); end
      m_ptr = (tid[t] + 1) % N;
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] pending;
    obs_t o;
    do_reset();
    for (int i = 0; i < N; i++) load_op(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
    pending = '1;
    for (int t = 0; t < N; t++) begin
      int   w;
      res_t e;
      w = model_winner(pending, m_ptr);
      e = model_alu(a_val[w], b_val[w], s_val[w]);
      run_txn(pending, o);
      checks++; if (o.g0 !== (N'(1) << w)) begin errors++; $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", t, o.g0, N'(1) << w); end
      checks++; if ({o.busy1, o.g1} !== {1'b1, N'(0)})
        begin errors++; $display("[TB] FAIL rr_busy_nogrant[%0d]: got busy=%b gnt=%b expected busy=1 gnt=0", t, o.busy1, o.g1); end
      checks++; if ({o.v2, o.id} !== {1'b1, IDW'(w)})
        begin errors++; $display("[TB] FAIL rr_valid_id[%0d]: got valid=%b id=%0d expected valid=1 id=%0d", t, o.v2, o.id, w); end
      checks++; if ({o.f, o.flags} !== e) begin errors++; $display("[TB] FAIL rr_result[%0d]: got %h/%b expected %h/%b", t, o.f, o.flags, e.f, e.flags); end
      pending = pending & ~(N'(1) << w);
      m_ptr   = (w + 1) % N;
    end
  endtask

  task automatic test_wrap();
    obs_t o;
    load_op(0, 32'd100, 32'd23, 1'b1);
    load_op(N - 1, 32'd7, 32'd8, 1'b0);
    run_txn(N'(1) | (N'(1) << (N - 1)), o);
    checks++; if (o.g0 !== N'(1)) begin errors++; $display("[TB] FAIL wrap_first_gnt: got %b expected %b", o.g0, N'(1)); end
    checks++; if (o.f !== 32'd77) begin errors++; $display("[TB] FAIL wrap_first_f: got %h expected %h", o.f, 32'd77); end
    m_ptr = 1;
    run_txn(N'(1) << (N - 1), o);
    checks++; if (o.g0 !== (N'(1) << (N - 1))) begin errors++; $display("[TB] FAIL wrap_second_gnt: got %b expected %b", o.g0, N'(1) << (N - 1)); end
    checks++; if (o.f !== 32'd15) begin errors++; $display("[TB] FAIL wrap_second_f: got %h expected %h", o.f, 32'd15); end
    m_ptr = 0;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] mask;
    int           w, w2;
    res_t         e, e2;
    obs_t         o;
    mask = 4'b0110;
    load_op(1, $urandom, $urandom, 1'b1);
    load_op(2, $urandom, $urandom, 1'b0);
    w = model_winner(mask, m_ptr);
    e = model_alu(a_val[w], b_val[w], s_val[w]);
    req = mask;
    #1;
    checks++; if (gnt !== (N'(1) << w)) begin errors++; $display("[TB] FAIL bp_gnt: got %b expected %b", gnt, N'(1) << w); end
    step();
    req = mask & ~(N'(1) << w);
    rsp_ready = 1'b0;
    step();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({rsp_valid, busy, gnt, rsp_f, rsp_of, rsp_sf, rsp_zf, rsp_cf, rsp_id} !== {1'b1, 1'b1, N'(0), e.f, e.flags, IDW'(w)}) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b busy=%b gnt=%b f=%h flags=%b id=%0d expected valid=1 busy=1 gnt=0 f=%h flags=%b id=%0d",
                 c, rsp_valid, busy, gnt, rsp_f, {rsp_of, rsp_sf, rsp_zf, rsp_cf}, rsp_id, e.f, e.flags, w);
      end
      if (c < 5) step();
    end
    rsp_ready = 1'b1;
    step();
    m_ptr = (w + 1) % N;
    mask  = mask & ~(N'(1) << w);
    w2 = model_winner(mask, m_ptr);
    e2 = model_alu(a_val[w2], b_val[w2], s_val[w2]);
    run_txn(mask, o);
    checks++; if (o.g0 !== (N'(1) << w2)) begin errors++; $display("[TB] FAIL bp_next_gnt: got %b expected %b", o.g0, N'(1) << w2); end
    checks++; if ({o.f, o.flags} !== e2) begin errors++; $display("[TB] FAIL bp_next_result: got %h/%b expected %h/%b", o.f, o.flags, e2.f, e2.flags); end
    m_ptr = (w2 + 1) % N;
  endtask

  task automatic test_random();
    obs_t o;
    req = '0;
    #1;
    checks++; if ({gnt, busy} !== {N'(0), 1'b0}) begin errors++; $display("[TB] FAIL idle_no_req: got gnt=%b busy=%b expected 0/0", gnt, busy); end
    step();
    for (int t = 0; t < 24; t++) begin
      logic [N-1:0] mask;
      int           w;
      res_t         e;
      for (int i = 0; i < N; i++) load_op(i, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
      mask = N'($urandom_range(1, (1 << N) - 1));
      w = model_winner(mask, m_ptr);
      e = model_alu(a_val[w], b_val[w], s_val[w]);
      run_txn(mask, o);
      checks++; if (o.g0 !== (N'(1) << w)) begin errors++; $display("[TB] FAIL rand_gnt[%0d]: got %b expected %b", t, o.g0, N'(1) << w); end
      checks++; if ({o.g1, o.v1, o.v2} !== {N'(0), 1'b0, 1'b1})
        begin errors++; $display("[TB] FAIL rand_timing[%0d]: got gnt1=%b v1=%b v2=%b expected 0/0/1", t, o.g1, o.v1, o.v2); end
      checks++; if (o.id !== IDW'(w)) begin errors++; $display("[TB] FAIL rand_id[%0d]: got %0d expected %0d", t, o.id, w); end
      checks++; if ({o.f, o.flags} !== e) begin errors++; $display("[TB] FAIL rand_result[%0d]: got %h/%b expected %h/%b", t, o.f, o.flags, e.f, e.flags); end
      m_ptr = (w + 1) % N;
    end
  endtask

  task automatic test_reset_in_exec();
    obs_t o;
    load_op(2, 32'h1234_5678, 32'h0000_0001, 1'b0);
    run_txn(4'b0100, o);
    m_ptr = 3;
    load_op(3, 32'h0000_0010, 32'h0000_0020, 1'b0);
    req = 4'b1000;
    step();
    req = '0;
    #1;
    rst = 1'b1;
    #1;
    checks++; if ({gnt, busy, rsp_valid} !== {N'(0), 1'b0, 1'b0})
      begin errors++; $display("[TB] FAIL exec_rst_ctrl: got gnt=%b busy=%b valid=%b expected 0", gnt, busy, rsp_valid); end
    checks++; if (rsp_f !== '0)  begin errors++; $display("[TB] FAIL exec_rst_f: got %h expected 0", rsp_f); end
    checks++; if (rsp_id !== '0) begin errors++; $display("[TB] FAIL exec_rst_id: got %0d expected 0", rsp_id); end
    checks++; if ({rsp_of, rsp_sf, rsp_zf, rsp_cf} !== 4'b0)
      begin errors++; $display("[TB] FAIL exec_rst_flags: got %b expected 0000", {rsp_of, rsp_sf, rsp_zf, rsp_cf}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    m_ptr = 0;
    for (int c = 0; c < 4; c++) begin
      checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("[TB] FAIL exec_rst_no_rsp[%0d]: got valid=%b busy=%b expected 0/0", c, rsp_valid, busy); end
      step();
    end
    load_op(1, 32'd9, 32'd4, 1'b1);
    load_op(3, 32'd1, 32'd1, 1'b0);
    run_txn(4'b1010, o);
    checks++; if (o.g0 !== 4'b0010) begin errors++; $display("[TB] FAIL exec_rst_next_gnt: got %b expected 0010", o.g0); end
    checks++; if ({o.f, o.id} !== {32'd5, IDW'(1)}) begin errors++; $display("[TB] FAIL exec_rst_next_rsp: got f=%h id=%0d expected f=5 id=1", o.f, o.id); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_random();
    test_reset_in_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
